// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the shift-register serial link.
// Holds the receiver state encoding so that the transmitter and link monitor
// decode the same values. Also holds the default word width.
package shift_deserializer_pkg;

    // Default word width of the link, in bits
    localparam int DEFAULT_W = 4;

    // Frame state: IDLE = no frame open, RECV = frame open and bits being taken
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } link_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// Counts the serial bits taken within the frame that is currently open.
// Ports:
//   clk      clock, state changes on posedge
//   rst      asynchronous active-high reset, clears the count
//   load     frame start: count becomes 1 (the MSB has just been taken)
//   inc      one more non-final bit taken: count increments
//   clear    word completed: count returns to 0
//   terminal high while count == W-1, i.e. the next bit completes the word
// Priority is clear > load > inc. The count never wraps, because the owner
// clears it on the bit that completes the word.
module frame_bit_counter
    import shift_deserializer_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    input  logic clear,
    output logic terminal
);

    localparam int CW = $clog2(W);

    logic [CW-1:0] count_r;

    // Bit counter register with clear/load/increment priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= CW'(1);
        end else if (inc) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == CW'(W - 1));

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver for the shift-register link.
// Captures an MSB-first bit stream and rebuilds W-bit words. Each completed
// word is presented with its complement behind a valid/acknowledge handshake.
// Ports:
//   C   clock (posedge)
//   R   asynchronous active-high reset
//   SI  serial data bit, sampled only while SV=1
//   SV  serial valid
//   F   frame start (qualified by SV); SI is the MSB of a new word
//   A   acknowledge; the consumer has taken Q while V=1
//   Q   last completed word (registered)
//   nQ  complement of Q (registered, updated together with Q)
//   V   word valid, held until acknowledged
//   OV  overrun: a word completed while the previous one was unacknowledged.
//       It is sticky until R.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         C,
    input  logic         R,
    input  logic         SI,
    input  logic         SV,
    input  logic         F,
    input  logic         A,
    output logic [W-1:0] Q,
    output logic [W-1:0] nQ,
    output logic         V,
    output logic         OV
);

    link_state_t   state_r;
    link_state_t   state_nxt_s;

    // Only the low W-1 bits of the shift register are ever observed. The top
    // bit is always shifted out before a word completes, so it is not stored.
    logic [W-2:0]  sr_r;
    logic [W-2:0]  sr_nxt_s;
    logic [W-1:0]  word_s;

    logic [W-1:0]  q_r;
    logic [W-1:0]  q_nxt_s;
    logic [W-1:0]  nq_r;
    logic [W-1:0]  nq_nxt_s;
    logic          v_r;
    logic          v_nxt_s;
    logic          ov_r;
    logic          ov_nxt_s;

    logic          cnt_load_s;
    logic          cnt_inc_s;
    logic          cnt_clear_s;
    logic          cnt_terminal_s;
    logic          done_s;

    assign word_s = {sr_r, SI};

    frame_bit_counter #(
        .W (W)
    ) u_frame_bit_counter (
        .clk      (C),
        .rst      (R),
        .load     (cnt_load_s),
        .inc      (cnt_inc_s),
        .clear    (cnt_clear_s),
        .terminal (cnt_terminal_s)
    );

    // Frame FSM next-state logic: shift control and word-completion detect
    always_comb begin
        state_nxt_s = state_r;
        sr_nxt_s    = sr_r;
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_clear_s = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (SV && F) begin
                    sr_nxt_s    = word_s[W-2:0];
                    cnt_load_s  = 1'b1;
                    state_nxt_s = ST_RECV;
                end else begin
                    // No frame open: bits without F are discarded
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (!SV) begin
                    // Gap in the stream: hold everything
                    state_nxt_s = ST_RECV;
                end else if (F) begin
                    // Restart: the partial word is abandoned and SI is the new MSB
                    sr_nxt_s    = word_s[W-2:0];
                    cnt_load_s  = 1'b1;
                    state_nxt_s = ST_RECV;
                end else if (cnt_terminal_s) begin
                    sr_nxt_s    = word_s[W-2:0];
                    cnt_clear_s = 1'b1;
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    sr_nxt_s    = word_s[W-2:0];
                    cnt_inc_s   = 1'b1;
                    state_nxt_s = ST_RECV;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_clear_s = 1'b1;
            end
        endcase
    end

    // Output handshake: publish a completed word, retire on acknowledge, flag overrun
    always_comb begin
        q_nxt_s  = q_r;
        nq_nxt_s = nq_r;
        v_nxt_s  = v_r;
        ov_nxt_s = ov_r;
        if (done_s) begin
            // An acknowledge on the completion edge frees the slot for the new word
            if (!v_r || A) begin
                q_nxt_s  = word_s;
                nq_nxt_s = ~word_s;
                v_nxt_s  = 1'b1;
            end else begin
                ov_nxt_s = 1'b1;
            end
        end else if (v_r && A) begin
            v_nxt_s = 1'b0;
        end else begin
            v_nxt_s = v_r;
        end
    end

    // State, shift register and registered outputs
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_r <= ST_IDLE;
            sr_r    <= {(W-1){1'b0}};
            q_r     <= {W{1'b0}};
            nq_r    <= {W{1'b1}};
            v_r     <= 1'b0;
            ov_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sr_r    <= sr_nxt_s;
            q_r     <= q_nxt_s;
            nq_r    <= nq_nxt_s;
            v_r     <= v_nxt_s;
            ov_r    <= ov_nxt_s;
        end
    end

    assign Q  = q_r;
    assign nQ = nq_r;
    assign V  = v_r;
    assign OV = ov_r;

endmodule
